// File: rtl/gb_psum_pool_reader.sv
// gb_psum_pool_reader
// Pool-side reader of the GB_PSUM pool port. Sweeps PSUM addresses 0..last,
// takes a lane-wise signed max over windows of 1..4 consecutive addresses,
// then applies ReLU, a right shift and saturation to ACT_WIDTH before handing
// one result per window downstream. A one-cycle POOLGB_fnh pulse releases the
// GB once the last window has been accepted.

module gb_psum_pool_reader #(
    parameter int NUM_PEB    = 16,
    parameter int PSUM_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ACT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            CFGPOOL_val,
    output logic                            POOLCFG_rdy,
    input  logic [ADDR_WIDTH-1:0]           CFGPOOL_last,
    input  logic [1:0]                      CFGPOOL_win,
    input  logic [4:0]                      CFGPOOL_shift,
    input  logic                            CCUPOOL_start,
    output logic                            POOL_idle,
    output logic [ADDR_WIDTH-1:0]           POOLGB_addr,
    output logic                            POOLGB_rdy,
    input  logic                            GBPOOL_val,
    input  logic [PSUM_WIDTH*NUM_PEB-1:0]   GBPOOL_data,
    output logic                            POOLGB_fnh,
    output logic                            POOLOUT_val,
    input  logic                            POOLOUT_rdy,
    output logic [ACT_WIDTH*NUM_PEB-1:0]    POOLOUT_data,
    output logic                            POOLOUT_last
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [1:0] ST_FNH  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSUM_WIDTH-1:0] ACT_MAX  =
        {{(PSUM_WIDTH-ACT_WIDTH){1'b0}}, {ACT_WIDTH{1'b1}}};

    logic [1:0]                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]             last_q, last_d;
    logic [1:0]                        win_q, win_d;
    logic [1:0]                        winCnt_q, winCnt_d;
    logic [4:0]                        shift_q, shift_d;
    logic [PSUM_WIDTH*NUM_PEB-1:0]     acc_q, acc_d;
    logic [ACT_WIDTH*NUM_PEB-1:0]      outData_q, outData_d;
    logic                              outLast_q, outLast_d;

    logic [PSUM_WIDTH*NUM_PEB-1:0]     accMerged;
    logic [ACT_WIDTH*NUM_PEB-1:0]      actPooled;
    logic                              cfgFire;
    logic                              windowEnd;
    logic                              atLast;

    // Signed max of two psums, kept as raw bit patterns.
    function automatic logic [PSUM_WIDTH-1:0] maxSigned(
        input logic [PSUM_WIDTH-1:0] a,
        input logic [PSUM_WIDTH-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // ReLU, logical shift (value is non-negative after ReLU) and saturation.
    function automatic logic [ACT_WIDTH-1:0] toAct(
        input logic [PSUM_WIDTH-1:0] a,
        input logic [4:0]            sh
    );
        logic [PSUM_WIDTH-1:0] v;
        v = a[PSUM_WIDTH-1] ? '0 : a;
        v = v >> sh;
        if (v > ACT_MAX) begin
            return {ACT_WIDTH{1'b1}};
        end
        return v[ACT_WIDTH-1:0];
    endfunction

    assign cfgFire   = CFGPOOL_val && (state_q == ST_IDLE);
    assign atLast    = (addr_q == last_q);
    assign windowEnd = (winCnt_q == win_q) || atLast;

    assign POOLCFG_rdy  = (state_q == ST_IDLE);
    assign POOL_idle    = (state_q == ST_IDLE);
    assign POOLGB_rdy   = (state_q == ST_REQ);
    assign POOLGB_addr  = addr_q;
    assign POOLGB_fnh   = (state_q == ST_FNH);
    assign POOLOUT_val  = (state_q == ST_OUT);
    assign POOLOUT_data = outData_q;
    assign POOLOUT_last = (state_q == ST_OUT) && outLast_q;

    // Fold the incoming beat into the window accumulator and pre-compute the activation.
    always_comb begin
        accMerged = '0;
        actPooled = '0;
        for (int i = 0; i < NUM_PEB; i++) begin
            if (winCnt_q == 2'd0) begin
                accMerged[i*PSUM_WIDTH +: PSUM_WIDTH] = GBPOOL_data[i*PSUM_WIDTH +: PSUM_WIDTH];
            end else begin
                accMerged[i*PSUM_WIDTH +: PSUM_WIDTH] =
                    maxSigned(acc_q[i*PSUM_WIDTH +: PSUM_WIDTH],
                              GBPOOL_data[i*PSUM_WIDTH +: PSUM_WIDTH]);
            end
            actPooled[i*ACT_WIDTH +: ACT_WIDTH] =
                toAct(accMerged[i*PSUM_WIDTH +: PSUM_WIDTH], shift_q);
        end
    end

    // Sweep sequencing: config capture, address/window stepping and output hold.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        win_d     = win_q;
        winCnt_d  = winCnt_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        outData_d = outData_q;
        outLast_d = outLast_q;

        if (cfgFire) begin
            last_d  = CFGPOOL_last;
            win_d   = CFGPOOL_win;
            shift_d = CFGPOOL_shift;
        end

        case (state_q)
            ST_IDLE: begin
                if (CCUPOOL_start) begin
                    state_d  = ST_REQ;
                    addr_d   = '0;
                    winCnt_d = 2'd0;
                end
            end
            ST_REQ: begin
                if (GBPOOL_val) begin
                    acc_d = accMerged;
                    if (windowEnd) begin
                        state_d   = ST_OUT;
                        outData_d = actPooled;
                        outLast_d = atLast;
                    end else begin
                        addr_d   = addr_q + ADDR_ONE;
                        winCnt_d = winCnt_q + 2'd1;
                    end
                end
            end
            ST_OUT: begin
                if (POOLOUT_rdy) begin
                    if (outLast_q) begin
                        state_d = ST_FNH;
                    end else begin
                        state_d  = ST_REQ;
                        addr_d   = addr_q + ADDR_ONE;
                        winCnt_d = 2'd0;
                    end
                end
            end
            ST_FNH: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that also aborts a running sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            last_q    <= '0;
            win_q     <= 2'd0;
            winCnt_q  <= 2'd0;
            shift_q   <= 5'd0;
            acc_q     <= '0;
            outData_q <= '0;
            outLast_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            win_q     <= win_d;
            winCnt_q  <= winCnt_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            outData_q <= outData_d;
            outLast_q <= outLast_d;
        end
    end

endmodule
